// File: rtl/act_pkg.sv
// Shared mode encodings and elaboration-time generators for the sigmoid/tanh tables.
// Exponentials use 64-bit fixed-point integer math so that table contents are plain constants.
package act_pkg;

    localparam logic MODE_SIGMOID = 1'b0;
    localparam logic MODE_TANH    = 1'b1;

    localparam int     EXP_SHIFT = 24;
    localparam longint EXP_ONE   = longint'(1) << EXP_SHIFT;
    localparam longint EXP_M1    = 64'sd6171993;  // e^-1 scaled by 2^24

    function automatic longint exp_neg(input int k);
        longint acc = EXP_ONE;
        for (int j = 0; j < k; j++) begin
            acc = (acc * EXP_M1) >>> EXP_SHIFT;
        end
        return acc;
    endfunction

    // Round-half-up of num/den scaled by 2^frac_w, for non-negative operands.
    function automatic int round_div(input longint num, input longint den, input int frac_w);
        return int'(((num <<< (frac_w + 1)) + den) / (den <<< 1));
    endfunction

    function automatic int lut_entry(input logic mode, input int idx, input int addr_w,
                                     input int frac_w, input int data_w);
        int     x;
        int     ax;
        int     v;
        int     hi;
        longint e;
        x  = (idx >= (1 << (addr_w - 1))) ? idx - (1 << addr_w) : idx;
        ax = (x < 0) ? -x : x;
        if (mode == MODE_TANH) begin
            e = exp_neg(2 * ax);
            v = round_div(EXP_ONE - e, EXP_ONE + e, frac_w);
            if (x < 0) v = -v;
        end else begin
            e = exp_neg(ax);
            v = round_div((x < 0) ? e : EXP_ONE, EXP_ONE + e, frac_w);
        end
        hi = (1 << (data_w - 1)) - 1;
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
        return v;
    endfunction

endpackage

// File: rtl/act_lut.sv
// Dual activation table: returns the entry at addr and its upper neighbour for interpolation.
// The neighbour of the most positive address is clamped to itself instead of wrapping negative.
module act_lut
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic [DATA_W-FRAC_W-1:0] addr,
    input  logic                     mode,
    output logic [DATA_W-1:0]        base,
    output logic [DATA_W-1:0]        nxt
);

    localparam int ADDR_W = DATA_W - FRAC_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = {1'b0, {(ADDR_W-1){1'b1}}};

    logic [DATA_W-1:0] tab_sig  [DEPTH];
    logic [DATA_W-1:0] tab_tanh [DEPTH];
    logic [ADDR_W-1:0] addr_up;

    for (genvar i = 0; i < DEPTH; i++) begin : g_tab
        localparam int SIG_V  = lut_entry(MODE_SIGMOID, i, ADDR_W, FRAC_W, DATA_W);
        localparam int TANH_V = lut_entry(MODE_TANH, i, ADDR_W, FRAC_W, DATA_W);
        assign tab_sig[i]  = DATA_W'(SIG_V);
        assign tab_tanh[i] = DATA_W'(TANH_V);
    end

    always_comb begin
        addr_up = addr + 1'b1;
        base    = (mode == MODE_TANH) ? tab_tanh[addr] : tab_sig[addr];
        nxt     = (mode == MODE_TANH) ? tab_tanh[addr_up] : tab_sig[addr_up];
        if (addr == TOP_ADDR) nxt = base;
    end

endmodule

// File: rtl/act_interp_pipe.sv
// Three-stage piecewise-linear sigmoid/tanh evaluator with valid/ready flow control.
// Each stage advances independently when it is empty or its successor moves, so bubbles collapse.
module act_interp_pipe
    import act_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic              busy
);

    localparam int PROD_W = DATA_W + FRAC_W + 1;

    function automatic logic signed [PROD_W-1:0] mul_rem(input logic signed [DATA_W:0] d,
                                                         input logic [FRAC_W-1:0] r);
        logic signed [PROD_W-1:0] de;
        logic signed [PROD_W-1:0] re;
        de = PROD_W'(d);
        re = $signed(PROD_W'(r));
        return de * re;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        hi = PROD_W'({1'b0, {(DATA_W-1){1'b1}}});
        lo = ~hi;
        if (v > hi) return hi[DATA_W-1:0];
        if (v < lo) return lo[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] lut_base;
    logic signed [DATA_W-1:0] lut_nxt;
    logic en_p1, en_p2, en_p3;

    logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic signed [DATA_W-1:0] base_p1_q, base_p1_d, base_p2_q, base_p2_d;
    logic signed [DATA_W:0]   diff_p1_q, diff_p1_d;
    logic [FRAC_W-1:0]        rem_p1_q, rem_p1_d;
    logic signed [PROD_W-1:0] prod_p2_q, prod_p2_d;
    logic signed [DATA_W-1:0] out_a_q, out_a_d;

    act_lut #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lut (
        .addr (in_z[DATA_W-1:FRAC_W]),
        .mode (in_mode),
        .base (lut_base),
        .nxt  (lut_nxt)
    );

    always_comb begin
        en_p3 = !vld_p3_q || out_ready;
        en_p2 = !vld_p2_q || en_p3;
        en_p1 = !vld_p1_q || en_p2;
        in_ready = en_p3;

        vld_p1_d  = vld_p1_q;
        base_p1_d = base_p1_q;
        diff_p1_d = diff_p1_q;
        rem_p1_d  = rem_p1_q;
        vld_p2_d  = vld_p2_q;
        base_p2_d = base_p2_q;
        prod_p2_d = prod_p2_q;
        vld_p3_d  = vld_p3_q;
        out_a_d   = out_a_q;

        // S1: table lookup, neighbour difference and remainder
        if (en_p1) begin
            vld_p1_d  = in_valid && in_ready;
            base_p1_d = lut_base;
            diff_p1_d = {lut_nxt[DATA_W-1], lut_nxt} - {lut_base[DATA_W-1], lut_base};
            rem_p1_d  = in_z[FRAC_W-1:0];
        end
        // S2: slope times remainder
        if (en_p2) begin
            vld_p2_d  = vld_p1_q;
            base_p2_d = base_p1_q;
            prod_p2_d = mul_rem(diff_p1_q, rem_p1_q);
        end
        // S3: floor-shifted add and saturation
        if (en_p3) begin
            vld_p3_d = vld_p2_q;
            out_a_d  = sat_data(PROD_W'(base_p2_q) + (prod_p2_q >>> FRAC_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            out_a_q  <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            out_a_q  <= out_a_d;
        end
    end

    always_ff @(posedge clk) begin
        base_p1_q <= base_p1_d;
        diff_p1_q <= diff_p1_d;
        rem_p1_q  <= rem_p1_d;
        base_p2_q <= base_p2_d;
        prod_p2_q <= prod_p2_d;
    end

    assign out_valid = vld_p3_q;
    assign out_a     = out_a_q;
    assign busy      = vld_p1_q || vld_p2_q || vld_p3_q;

endmodule

// File: tb/tb_act_interp_pipe.sv
// Directed bench for act_interp_pipe: latency, stalls, async reset and a full sweep of both modes.
module tb_act_interp_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_z = 8'h00;
    logic       in_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_a;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Hand-computed round(f(x)*16), index = two's-complement address 0..15 (x = 0..7, -8..-1)
    int SIG_T  [16] = '{8, 12, 14, 15, 16, 16, 16, 16, 0, 0, 0, 0, 0, 1, 2, 4};
    int TANH_T [16] = '{0, 12, 15, 16, 16, 16, 16, 16, -16, -16, -16, -16, -16, -16, -15, -12};

    act_interp_pipe #(.DATA_W(8), .FRAC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic mode, input logic [7:0] z);
        logic [3:0] ad;
        int base, nxt, rem, a;
        ad   = z[7:4];
        rem  = int'(z[3:0]);
        base = mode ? TANH_T[ad] : SIG_T[ad];
        if (ad == 4'd7) nxt = base;
        else nxt = mode ? TANH_T[ad + 4'd1] : SIG_T[ad + 4'd1];
        a = base + (((nxt - base) * rem) >>> 4);
        if (a > 127) a = 127;
        if (a < -128) a = -128;
        return a[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: out_valid must appear exactly three cycles after presentation.
    task automatic send_one(input string tag, input logic mode, input logic [7:0] z,
                            input logic [7:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_z      = z;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_v1"}, out_valid, 0);
        step();
        check({tag, "_v2"}, out_valid, 0);
        step();
        check({tag, "_v3"}, out_valid, 1);
        check(tag, out_a, exp);
        step();
        check({tag, "_drain"}, busy, 0);
    endtask

    logic [7:0] sz [8] = '{8'h08, 8'hF8, 8'h13, 8'hE5, 8'h7F, 8'h80, 8'h2A, 8'hC7};
    logic [7:0] expq [$];

    initial begin
        int sent, rcv, cyc;
        logic prev_stall;
        logic [7:0] prev_a;
        logic [8:0] k;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_a", out_a, 8'h00);
        check("rst_in_ready", in_ready, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // Directed single samples
        send_one("sig_0p5", 1'b0, 8'h08, 8'h0A);
        send_one("tanh_m0p5", 1'b1, 8'hF8, 8'hFA);
        send_one("sig_max", 1'b0, 8'h7F, 8'h10);
        send_one("tanh_min", 1'b1, 8'h80, 8'hF0);
        send_one("sig_neg", 1'b0, 8'hE8, model(1'b0, 8'hE8));
        send_one("tanh_pos", 1'b1, 8'h1C, model(1'b1, 8'h1C));

        // Back-to-back alternating modes with downstream stall in cycles 4..6
        sent = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_a = 8'h00;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_z     = sz[sent];
                in_mode  = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("stall_in_ready", in_ready, !(c >= 4 && c <= 6));
            if (prev_stall) begin
                check("stall_hold_v", out_valid, 1);
                check("stall_hold_a", out_a, prev_a);
            end
            if (out_valid && out_ready) begin
                if (rcv < 8) check("stall_out", out_a, model(rcv[0], sz[rcv]));
                else check("stall_extra_out", out_valid, 0);
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_a = out_a;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_sent", sent, 8);
        check("stall_rcv", rcv, 8);

        // Asynchronous reset with three samples in flight
        in_valid = 1'b1;
        in_mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_z = sz[i];
            step();
        end
        in_valid = 1'b0;
        check("flight_busy", busy, 1);
        check("flight_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_a", out_a, 8'h00);
        check("arst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_no_stale", out_valid, 0);
        end
        send_one("post_rst_sample", 1'b1, 8'h08, model(1'b1, 8'h08));

        // Exhaustive sweep, both modes, streamed back-to-back
        k = 9'd0;
        sent = 0;
        rcv = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (rcv < 512 && cyc < 700) begin
            if (sent < 512) begin
                in_valid = 1'b1;
                in_mode  = k[8];
                in_z     = k[7:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() > 0) check("sweep", out_a, expq.pop_front());
                else check("sweep_extra_out", out_valid, 0);
                rcv++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(k[8], k[7:0]));
                sent++;
                k = k + 9'd1;
            end
            cyc++;
            step();
        end
        in_valid = 1'b0;
        check("sweep_count", rcv, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_interp_pipe.md
ACT_INTERP_PIPE -- requirements
Module: act_interp_pipe

Interface
- REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning signed fixed-point width of input z and output a.
- REQ-002 The block SHALL expose parameter FRAC_W, default 4, meaning fraction bits, also the interpolation remainder width; ADDR_W = DATA_W-FRAC_W.
- REQ-003 The block SHALL expose ports, in order:
  - clk  input  1  single clock, rising edge
  - rst  input  1  asynchronous, active-high reset
  - in_valid  input  1  input sample present
  - in_ready  output  1  block accepts sample this cycle
  - in_z  input  DATA_W  signed sample, Q(ADDR_W).(FRAC_W)
  - in_mode  input  1  0 = sigmoid, 1 = tanh; sampled with in_z
  - out_valid  output  1  result present
  - out_ready  input  1  downstream accepts result
  - out_a  output  DATA_W  signed activation result, same Q format
  - busy  output  1  any pipeline stage holds a valid sample

Function
- REQ-004 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
- REQ-005 The pipeline SHALL have 3 stages (S1 lookup, S2 multiply, S3 add/saturate); latency from input transfer to out_valid SHALL be 3 cycles when unstalled.
- REQ-006 Throughput SHALL be one sample per cycle while out_ready=1.
- REQ-007 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold; in_ready SHALL be 0 only in this condition (in_ready = !out_valid || out_ready).
- REQ-008 Bubbles SHALL advance while stalled stages hold nothing; out_a SHALL be stable while out_valid=1 and out_ready=0.
- REQ-009 S1 SHALL take address = in_z[DATA_W-1:FRAC_W] as unsigned LUT index (two's-complement table order) and rem = in_z[FRAC_W-1:0] as unsigned.
- REQ-010 S1 SHALL read base = LUT[mode][address], next = LUT[mode][address+1 mod 2^ADDR_W], except at address 2^(ADDR_W-1)-1 (most positive) where next = base.
- REQ-011 S2 SHALL compute prod = (next-base)*rem at DATA_W+FRAC_W+1 bits signed, no overflow.
- REQ-012 S3 SHALL compute a = base + (prod >>> FRAC_W) (arithmetic shift, truncation toward -inf), saturated to DATA_W signed range.
- REQ-013 LUT entry i SHALL equal round(f(x_i)*2^FRAC_W), x_i = signed(i), f = sigmoid or tanh, saturated to DATA_W signed.
- REQ-014 Mode SHALL travel with its sample; mixed modes in consecutive cycles SHALL each be evaluated with their own table.
- REQ-015 busy SHALL be OR of the three stage valid flags.

Reset
- REQ-016 rst=1 SHALL immediately clear all stage valids: out_valid=0, busy=0, out_a=0; in_ready SHALL read 1 during reset.
- REQ-017 Reset mid-operation SHALL discard in-flight samples; no output for them SHALL appear after release.
- REQ-018 Datapath registers other than out_a need no reset.

Structure
- REQ-019 Package act_pkg SHALL hold the mode constants (MODE_SIGMOID=0, MODE_TANH=1) and the LUT generation functions.
- REQ-020 Sub-module act_lut SHALL hold both tables and implement REQ-010 combinationally (address, mode -> base, next); remaining logic is in act_interp_pipe.

Verification
- REQ-021 Sigmoid, z=0x08 (0.5) -> after 3 cycles out_a=0x0A (base 8, next 12).
- REQ-022 Tanh, z=0xF8 (-0.5) -> out_a=0xFA (-6; base -12, next 0, rem 8).
- REQ-023 Sigmoid z=0x7F (max positive) -> out_a=LUT[7] (next clamped, no wrap to negative); tanh z=0x80 -> out_a=0xF0 (-16).
- REQ-024 Back-to-back 8 samples alternating mode with out_ready=0 for cycles 4-6 -> in_ready low exactly those cycles, all 8 results in order, none lost or duplicated, out_a stable while stalled.
- REQ-025 Assert rst asynchronously with 3 samples in flight -> out_valid and busy drop same cycle; after release no stale output appears; next sample gives correct result at latency 3.
- REQ-026 Exhaustive sweep both modes, all 256 z -> out_a matches reference model of REQ-009..REQ-013 bit-exactly.
